// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controller and its output buffer.
package fifo_rd_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned BUF_DEPTH      = 2;
  localparam int unsigned BUF_CNT_WIDTH  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_WIDTH      = BUF_CNT_WIDTH + 1;
  localparam int unsigned UF_CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: entry 0 is the stream head, entry 1 holds the word behind it.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [BUF_CNT_WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == BUF_CNT_WIDTH'(0)) head <= din;
          else                          tail <= din;
          cnt <= cnt + BUF_CNT_WIDTH'(1);
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - BUF_CNT_WIDTH'(1);
        end
        2'b11: begin
          // Count unchanged: the new word lands wherever the head moves out of.
          if (cnt == BUF_CNT_WIDTH'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: issues FIFO reads, buffers the one-cycle read latency, streams valid/ready.
// Optional underflow checking is enabled by defining FIFO_RD_CTRL_UNDERFLOW_CHK_EN.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    fifo_empty,
  input  logic                    fifo_underflow,
  input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
  output logic                    fifo_rd_en,
  output logic [FIFO_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    flush_done,
`ifdef FIFO_RD_CTRL_UNDERFLOW_CHK_EN
  output logic                    err_underflow,
  output logic [UF_CNT_WIDTH-1:0] uf_cnt,
`endif
  output logic [CNT_WIDTH-1:0]    word_cnt
);

  rd_state_e                state;
  logic                     inflight;
  logic [BUF_CNT_WIDTH-1:0] buf_cnt;
  logic [OCC_WIDTH-1:0]     occ;
  logic                     pop;
  logic                     push;

  assign pop     = m_valid && m_ready;
  assign m_valid = (buf_cnt != BUF_CNT_WIDTH'(0));
  assign busy    = (state != IDLE) || (buf_cnt != BUF_CNT_WIDTH'(0)) || inflight;

  // Occupancy the buffer will have once this cycle's in-flight word and pop settle.
  assign occ = OCC_WIDTH'(buf_cnt) + OCC_WIDTH'(inflight) - OCC_WIDTH'(pop);

  // Returning data is dropped while flushing, including the cycle flush is raised.
  assign push = inflight && (state != FLUSH) && !flush;

  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      RUN:     fifo_rd_en = !fifo_empty && (occ < OCC_WIDTH'(BUF_DEPTH));
      FLUSH:   fifo_rd_en = !fifo_empty;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  fifo_rd_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_data_out),
    .head  (m_data),
    .cnt   (buf_cnt)
  );

  // Control FSM with the registered flush_done pulse on FLUSH->IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush)       state <= FLUSH;
          else if (enable) state <= RUN;
        end
        RUN: begin
          if (flush)        state <= FLUSH;
          else if (!enable) state <= IDLE;
        end
        FLUSH: begin
          if (!flush && fifo_empty && !inflight) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency tracker and saturating delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop && (word_cnt != {CNT_WIDTH{1'b1}})) word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef FIFO_RD_CTRL_UNDERFLOW_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow <= 1'b0;
      uf_cnt        <= '0;
    end else begin
      if (fifo_underflow || (fifo_rd_en && fifo_empty)) err_underflow <= 1'b1;
      if (fifo_underflow && (uf_cnt != {UF_CNT_WIDTH{1'b1}})) uf_cnt <= uf_cnt + UF_CNT_WIDTH'(1);
    end
  end
`else
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural FIFO (one-cycle registered read data).
module tb_fifo_rd_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] fifo_data_out;
  logic        fifo_rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        flush_done;
  logic [15:0] word_cnt;
`ifdef FIFO_RD_CTRL_UNDERFLOW_CHK_EN
  logic        err_underflow;
  logic [7:0]  uf_cnt;
`endif

  fifo_rd_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .busy           (busy),
    .flush_done     (flush_done),
`ifdef FIFO_RD_CTRL_UNDERFLOW_CHK_EN
    .err_underflow  (err_underflow),
    .uf_cnt         (uf_cnt),
`endif
    .word_cnt       (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: pointers grow monotonically, data registered one cycle after a read.
  logic [15:0] mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Stream and protocol monitor, sampled on the falling edge.
  logic [15:0] rx [0:255];
  int rx_n = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  int bad_rd = 0;
  int ovf = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        rx[rx_n[7:0]] = m_data;
        rx_n = rx_n + 1;
      end
      if (fifo_rd_en) rd_cnt = rd_cnt + 1;
      if (fifo_rd_en && fifo_empty) bad_rd = bad_rd + 1;
      if (flush_done) fd_cnt = fd_cnt + 1;
      if (dut.u_skid.push && !dut.u_skid.pop && (dut.u_skid.cnt == 2'd2)) ovf = ovf + 1;
    end
  end

  int vecs = 0;
  int errs = 0;
  int rx0;
  int rd0;
  int fd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs = vecs + 1;
    assert (obs === exp) else begin
      errs = errs + 1;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    fifo_data_out = 16'h0;
    step(2);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
`ifdef FIFO_RD_CTRL_UNDERFLOW_CHK_EN
    check("rst_err_uf", 32'(err_underflow), 32'd0);
    check("rst_uf_cnt", 32'(uf_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Streaming: 8 words, sink always ready.
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    rd0 = rd_cnt;
    m_ready = 1'b1; enable = 1'b1;
    step(1);
    check("st_rd_en_c1", 32'(fifo_rd_en), 32'd1);
    check("st_valid_c1", 32'(m_valid), 32'd0);
    step(1);
    check("st_valid_c2", 32'(m_valid), 32'd0);
    step(1);
    check("st_valid_c3", 32'(m_valid), 32'd1);
    check("st_data_1", 32'(m_data), 32'h0001);
    for (int k = 2; k <= 8; k++) begin
      step(1);
      check("st_valid", 32'(m_valid), 32'd1);
      check("st_data", 32'(m_data), 32'(k));
    end
    step(1);
    check("st_drained", 32'(m_valid), 32'd0);
    check("st_rd_off", 32'(fifo_rd_en), 32'd0);
    check("st_word_cnt", 32'(word_cnt), 32'd8);
    check("st_rd_count", 32'(rd_cnt - rd0), 32'd8);
    enable = 1'b0;
    step(1);
    check("st_busy_low", 32'(busy), 32'd0);

    // Backpressure: sink stalls 5 cycles mid-stream.
    for (int i = 1; i <= 6; i++) push_word(16'h0A00 + 16'(i));
    rd0 = rd_cnt; rx0 = rx_n;
    enable = 1'b1;
    step(3);
    check("bp_data_1", 32'(m_data), 32'h0A01);
    step(1);
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      check("bp_hold_data", 32'(m_data), 32'h0A02);
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_rd_stop", 32'(fifo_rd_en), 32'd0);
    end
    m_ready = 1'b1;
    step(8);
    check("bp_rx_count", 32'(rx_n - rx0), 32'd6);
    for (int i = 0; i < 6; i++) check("bp_rx_order", 32'(rx[8'(rx0 + i)]), 32'h0A01 + 32'(i));
    check("bp_rd_count", 32'(rd_cnt - rd0), 32'd6);
    check("bp_word_cnt", 32'(word_cnt), 32'd14);
    enable = 1'b0;
    step(1);

    // Empty boundary: a single word.
    push_word(16'h00B1);
    rd0 = rd_cnt;
    m_ready = 1'b0; enable = 1'b1;
    step(3);
    check("eb_valid", 32'(m_valid), 32'd1);
    check("eb_data", 32'(m_data), 32'h00B1);
    step(3);
    check("eb_valid_held", 32'(m_valid), 32'd1);
    check("eb_rd_count", 32'(rd_cnt - rd0), 32'd1);
    m_ready = 1'b1;
    step(1);
    check("eb_popped", 32'(m_valid), 32'd0);
    check("eb_word_cnt", 32'(word_cnt), 32'd15);
    enable = 1'b0; m_ready = 1'b0;
    step(1);

    // Flush: 2 words buffered, 3 left in the FIFO.
    for (int i = 1; i <= 5; i++) push_word(16'h0C00 + 16'(i));
    rd0 = rd_cnt; fd0 = fd_cnt;
    enable = 1'b1;
    step(4);
    check("fl_pre_valid", 32'(m_valid), 32'd1);
    check("fl_pre_rd", 32'(fifo_rd_en), 32'd0);
    flush = 1'b1;
    step(1);
    check("fl_valid_cleared", 32'(m_valid), 32'd0);
    check("fl_rd_drain", 32'(fifo_rd_en), 32'd1);
    flush = 1'b0; enable = 1'b0;
    step(4);
    check("fl_done_early", 32'(flush_done), 32'd0);
    check("fl_busy_draining", 32'(busy), 32'd1);
    step(1);
    check("fl_done_pulse", 32'(flush_done), 32'd1);
    check("fl_busy_idle", 32'(busy), 32'd0);
    check("fl_valid_after", 32'(m_valid), 32'd0);
    step(1);
    check("fl_done_once", 32'(flush_done), 32'd0);
    check("fl_done_count", 32'(fd_cnt - fd0), 32'd1);
    check("fl_rd_count", 32'(rd_cnt - rd0), 32'd5);
    check("fl_fifo_empty", 32'(fifo_empty), 32'd1);
    check("fl_word_cnt", 32'(word_cnt), 32'd15);

    // Asynchronous reset mid-stream with a word buffered and one in flight.
    for (int i = 1; i <= 6; i++) push_word(16'h0D00 + 16'(i));
    m_ready = 1'b1; enable = 1'b1;
    step(3);
    check("rs_pre_data", 32'(m_data), 32'h0D01);
    #2 rst = 1'b1;
    #1;
    check("rs_valid", 32'(m_valid), 32'd0);
    check("rs_data", 32'(m_data), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rs_word_cnt", 32'(word_cnt), 32'd0);
    enable = 1'b0;
    step(1);
    rst = 1'b0;
    rx0 = rx_n;
    enable = 1'b1;
    step(3);
    check("rs_restart_valid", 32'(m_valid), 32'd1);
    check("rs_restart_data", 32'(m_data), 32'h0D03);
    step(6);
    check("rs_rx_count", 32'(rx_n - rx0), 32'd4);
    for (int i = 0; i < 4; i++) check("rs_rx_order", 32'(rx[8'(rx0 + i)]), 32'h0D03 + 32'(i));
    check("rs_word_cnt_after", 32'(word_cnt), 32'd4);
    enable = 1'b0;
    step(1);

    // Saturation of the delivered-word counter.
    force dut.word_cnt = 16'hFFFE;
    #1 release dut.word_cnt;
    rx0 = rx_n;
    for (int i = 1; i <= 3; i++) push_word(16'h0E00 + 16'(i));
    enable = 1'b1;
    step(8);
    check("sat_rx_count", 32'(rx_n - rx0), 32'd3);
    check("sat_word_cnt", 32'(word_cnt), 32'hFFFF);
    enable = 1'b0;
    step(1);

`ifdef FIFO_RD_CTRL_UNDERFLOW_CHK_EN
    fifo_underflow = 1'b1;
    step(1);
    fifo_underflow = 1'b0;
    check("uf_err_set", 32'(err_underflow), 32'd1);
    check("uf_cnt_one", 32'(uf_cnt), 32'd1);
    step(3);
    check("uf_err_sticky", 32'(err_underflow), 32'd1);
    check("uf_cnt_held", 32'(uf_cnt), 32'd1);
    rst = 1'b1;
    #1;
    check("uf_err_rst", 32'(err_underflow), 32'd0);
    check("uf_cnt_rst", 32'(uf_cnt), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
`endif

    check("no_rd_when_empty", 32'(bad_rd), 32'd0);
    check("no_buffer_overflow", 32'(ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
